// File: rtl/hashcore_pkg.sv
// Shared types for the hash-core result path: nonce width, core-id width helper and FIFO entry.
package hashcore_pkg;

  localparam int GN_NONCE_W   = 32;
  localparam int GN_CID_MAX_W = 5;

  function automatic int cid_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Saturating 16-bit accumulate used by the optional statistics counters
  function automatic logic [15:0] sat16_add(input logic [15:0] a, input int b);
    int s;
    s = int'(a) + b;
    return (s > 65535) ? 16'hFFFF : s[15:0];
  endfunction

  typedef struct packed {
    logic [GN_CID_MAX_W-1:0] core_id;
    logic [GN_NONCE_W-1:0]   nonce;
  } gn_entry_t;

endpackage

// File: rtl/gn_fifo.sv
// First-word-fall-through FIFO with occupancy count; head reads as zero while empty.
module gn_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          hash_clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign full   = (r_count == CW'(DEPTH));
  assign empty  = (r_count == '0);
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;
  assign count  = r_count;
  assign head   = empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge hash_clk) begin
    if (w_push && !flush) r_mem[r_wr_ptr] <= push_data;
  end

  // Count alone distinguishes full from empty, so pointers wrap naturally at DEPTH
  always_ff @(posedge hash_clk) begin
    if (reset || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

endmodule

// File: rtl/golden_nonce_arbiter.sv
// Captures per-core golden-nonce strobes and round-robin queues them for the host link.
// Optional GN_STATS_EN adds saturating match/drop counters.
module golden_nonce_arbiter
  import hashcore_pkg::*;
#(
  parameter int  NUM_CORES  = 4,
  parameter int  FIFO_DEPTH = 8,
  parameter int  NONCE_W    = GN_NONCE_W,
  localparam int CID_W      = cid_w(NUM_CORES),
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                         hash_clk,
  input  logic                         reset,
  input  logic [NUM_CORES-1:0]         core_match,
  input  logic [NUM_CORES*NONCE_W-1:0] core_nonce,
  input  logic                         flush,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NONCE_W-1:0]           out_nonce,
  output logic [CID_W-1:0]             out_core,
  output logic [CNT_W-1:0]             fifo_count,
  output logic                         overflow,
`ifdef GN_STATS_EN
  output logic [15:0]                  stat_matches,
  output logic [15:0]                  stat_drops,
`endif
  input  logic                         overflow_clr
);

  logic [NUM_CORES-1:0] r_pend;
  logic [NUM_CORES-1:0] w_pend_next;
  logic [NONCE_W-1:0]   r_hold [NUM_CORES];
  logic [NONCE_W-1:0]   w_nonce_in [NUM_CORES];
  logic [CID_W-1:0]     r_rr_ptr;
  logic                 r_overflow;
  logic [NUM_CORES-1:0] w_grant_vec;
  logic [NUM_CORES-1:0] w_ovf_vec;
  logic [CID_W-1:0]     w_grant_idx;
  logic                 w_grant_valid;
  logic                 w_full;
  logic                 w_empty;
  gn_entry_t            w_push_entry;
  gn_entry_t            w_head;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CORES; gi++) begin : g_core
      assign w_nonce_in[gi] = core_nonce[gi*NONCE_W +: NONCE_W];
      // A fresh strobe on a still-waiting core replaces its result
      assign w_ovf_vec[gi]  = core_match[gi] & r_pend[gi] & ~w_grant_vec[gi] & ~flush;
    end
  endgenerate

  // Lowest pending index overall, then overridden by the lowest at or after rr_ptr
  always_comb begin
    w_grant_idx = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (r_pend[i]) w_grant_idx = CID_W'(i);
    end
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (r_pend[i] && (CID_W'(i) >= r_rr_ptr)) w_grant_idx = CID_W'(i);
    end
    w_grant_valid = (|r_pend) & ~w_full & ~flush;
    w_grant_vec   = w_grant_valid ? (NUM_CORES'(1) << w_grant_idx) : '0;
  end

  always_comb begin
    w_pend_next = r_pend;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (flush)               w_pend_next[i] = 1'b0;
      else if (core_match[i])  w_pend_next[i] = 1'b1;
      else if (w_grant_vec[i]) w_pend_next[i] = 1'b0;
    end
  end

  always_ff @(posedge hash_clk) begin
    if (reset) begin
      r_pend     <= '0;
      r_rr_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_pend <= w_pend_next;
      if (w_grant_valid)
        r_rr_ptr <= (w_grant_idx == CID_W'(NUM_CORES - 1)) ? '0 : w_grant_idx + 1'b1;
      if (|w_ovf_vec)        r_overflow <= 1'b1;
      else if (overflow_clr) r_overflow <= 1'b0;
    end
  end

  always_ff @(posedge hash_clk) begin
    for (int i = 0; i < NUM_CORES; i++) begin
      if (!reset && !flush && core_match[i]) r_hold[i] <= w_nonce_in[i];
    end
  end

  always_comb begin
    w_push_entry.core_id = GN_CID_MAX_W'(w_grant_idx);
    w_push_entry.nonce   = GN_NONCE_W'(r_hold[w_grant_idx]);
  end

  gn_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     ($bits(gn_entry_t))
  ) u_fifo (
    .hash_clk  (hash_clk),
    .reset     (reset),
    .flush     (flush),
    .push      (w_grant_valid),
    .push_data (w_push_entry),
    .pop       (out_valid & out_ready),
    .head      (w_head),
    .count     (fifo_count),
    .full      (w_full),
    .empty     (w_empty)
  );

  assign out_valid = ~w_empty;
  assign out_nonce = NONCE_W'(w_head.nonce);
  assign out_core  = CID_W'(w_head.core_id);
  assign overflow  = r_overflow;

`ifdef GN_STATS_EN
  logic [15:0] r_stat_matches;
  logic [15:0] r_stat_drops;
  int          w_match_add;
  int          w_drop_add;

  // A flush discards queued entries plus every pending or same-cycle result
  always_comb begin
    w_match_add = flush ? 0 : $countones(core_match);
    w_drop_add  = flush ? (int'(fifo_count) + $countones(r_pend | core_match))
                        : $countones(w_ovf_vec);
  end

  always_ff @(posedge hash_clk) begin
    if (reset) begin
      r_stat_matches <= '0;
      r_stat_drops   <= '0;
    end else begin
      r_stat_matches <= sat16_add(r_stat_matches, w_match_add);
      r_stat_drops   <= sat16_add(r_stat_drops, w_drop_add);
    end
  end

  assign stat_matches = r_stat_matches;
  assign stat_drops   = r_stat_drops;
`endif

endmodule
